// File: rtl/dest_drain_arb.sv
`default_nettype none
// ============================================================================
// Module  : dest_drain_arb
// Brief   : Round-robin drain of the D0/D1 destination FIFOs into one tagged
//           valid/ready stream, with saturating per-destination counters.
// Rev     : 1.0  initial release
// ============================================================================
module dest_drain_arb #(
    parameter int BW    = 6,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic             D0_empty,
    input  logic             D1_empty,
    input  logic [BW-1:0]    D0_data_out,
    input  logic [BW-1:0]    D1_data_out,
    output logic             D0_rd,
    output logic             D1_rd,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BW-1:0]    out_data,
    output logic             out_dest,
    output logic             idle_out,
    input  logic             cnt_req,
    input  logic             cnt_idx,
    output logic             cnt_valid,
    output logic [CNT_W-1:0] cnt_value
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_grant;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_any;
    logic             w_gnt;
    logic             w_xfer;
    logic             w_d0_rd_nxt;
    logic             w_d1_rd_nxt;
    logic             w_valid_nxt;
    logic [BW-1:0]    w_data_nxt;
    logic             w_dest_nxt;

    assign w_any    = !D0_empty || !D1_empty;
    // With both FIFOs pending, the one not served last wins; otherwise the
    // only non-empty one (D0_empty=1 implies D1 must be the requester).
    assign w_gnt    = (!D0_empty && !D1_empty) ? ~r_last_grant : D0_empty;
    assign w_xfer   = (r_state == S_HOLD) && out_valid && out_ready;
    assign idle_out = (r_state == S_IDLE) && D0_empty && D1_empty;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_REQ;
            S_REQ:   w_state_nxt = S_CAPT;
            S_CAPT:  w_state_nxt = S_HOLD;
            S_HOLD:  if (w_xfer) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_d0_rd_nxt = (r_state == S_IDLE) && w_any && !w_gnt;
        w_d1_rd_nxt = (r_state == S_IDLE) && w_any &&  w_gnt;
        w_valid_nxt = out_valid;
        w_data_nxt  = out_data;
        w_dest_nxt  = out_dest;
        case (r_state)
            S_CAPT: begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = r_grant ? D1_data_out : D0_data_out;
                w_dest_nxt  = r_grant;
            end
            S_HOLD: begin
                if (w_xfer) w_valid_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            D0_rd        <= 1'b0;
            D1_rd        <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_dest     <= 1'b0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            D0_rd     <= w_d0_rd_nxt;
            D1_rd     <= w_d1_rd_nxt;
            out_valid <= w_valid_nxt;
            out_data  <= w_data_nxt;
            out_dest  <= w_dest_nxt;
            if ((r_state == S_IDLE) && w_any) begin
                r_grant      <= w_gnt;
                r_last_grant <= w_gnt;
            end
        end
    end

    // init has priority over a same-cycle transfer.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (init) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_xfer) begin
            if (!r_grant && (r_cnt0 != C_CNT_MAX)) r_cnt0 <= r_cnt0 + C_CNT_ONE;
            if ( r_grant && (r_cnt1 != C_CNT_MAX)) r_cnt1 <= r_cnt1 + C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_valid <= 1'b0;
            cnt_value <= '0;
        end else begin
            cnt_valid <= cnt_req;
            if (cnt_req) cnt_value <= cnt_idx ? r_cnt1 : r_cnt0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dest_drain_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_dest_drain_arb
// Brief   : Randomized self-checking bench for dest_drain_arb against a
//           word-level round-robin / saturating-counter reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_dest_drain_arb;

    localparam int BW    = 6;
    localparam int CNT_W = 5;
    localparam int C_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_L = 1'b0;
    logic             init = 1'b0;
    logic             D0_empty = 1'b1;
    logic             D1_empty = 1'b1;
    logic [BW-1:0]    D0_data_out = '0;
    logic [BW-1:0]    D1_data_out = '0;
    logic             D0_rd;
    logic             D1_rd;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [BW-1:0]    out_data;
    logic             out_dest;
    logic             idle_out;
    logic             cnt_req = 1'b0;
    logic             cnt_idx = 1'b0;
    logic             cnt_valid;
    logic [CNT_W-1:0] cnt_value;

    dest_drain_arb #(.BW(BW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .D0_empty(D0_empty), .D1_empty(D1_empty),
        .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
        .D0_rd(D0_rd), .D1_rd(D1_rd),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_dest(out_dest), .idle_out(idle_out),
        .cnt_req(cnt_req), .cnt_idx(cnt_idx),
        .cnt_valid(cnt_valid), .cnt_value(cnt_value)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    logic [BW-1:0] m0[$];
    logic [BW-1:0] m1[$];
    logic [BW:0]   expq[$];
    logic          m_last = 1'b1;
    int            m_cnt[2] = '{0, 0};

    logic          x_fire;
    logic [BW-1:0] x_data;
    logic          x_dest;

    // One clock step; FIFO model pops on a sampled read strobe and presents
    // the word just after the edge, as the real FIFO does.
    task automatic tick();
        logic rd0, rd1;
        rd0    = D0_rd;
        rd1    = D1_rd;
        x_fire = out_valid && out_ready;
        x_data = out_data;
        x_dest = out_dest;
        @(posedge clk);
        #1;
        cyc++;
        if (rd0 && q0.size() > 0) D0_data_out = q0.pop_front();
        if (rd1 && q1.size() > 0) D1_data_out = q1.pop_front();
        D0_empty = (q0.size() == 0);
        D1_empty = (q1.size() == 0);
    endtask

    task automatic model_xfer(input logic [BW:0] e);
        if (m_cnt[e[BW]] < C_MAX) m_cnt[e[BW]]++;
    endtask

    // Loads m0/m1 into the FIFOs in one step and derives the expected order.
    task automatic build_model(input string name);
        logic [BW-1:0] a[$];
        logic [BW-1:0] b[$];
        logic g;
        nvec++;
        if (idle_out !== 1'b1) begin
            nerr++;
            $display("FAIL %s idle_before_load: got %b want 1", name, idle_out);
        end
        a = m0; b = m1;
        foreach (m0[i]) q0.push_back(m0[i]);
        foreach (m1[i]) q1.push_back(m1[i]);
        D0_empty = (q0.size() == 0);
        D1_empty = (q1.size() == 0);
        while (a.size() > 0 || b.size() > 0) begin
            if (a.size() > 0 && b.size() > 0) g = ~m_last;
            else                              g = (a.size() == 0);
            if (g) expq.push_back({1'b1, b.pop_front()});
            else   expq.push_back({1'b0, a.pop_front()});
            m_last = g;
        end
        m0.delete(); m1.delete();
    endtask

    task automatic run_drain(input string name, input int pct, input int budget);
        logic pv, prdy, pdst, prd0, prd1;
        logic [BW-1:0] pd;
        logic [BW:0] e;
        int last_fire;
        last_fire = -100;
        prd0 = 1'b0; prd1 = 1'b0;
        for (int i = 0; i < budget && expq.size() > 0; i++) begin
            out_ready = ($urandom_range(99) < pct);
            pv = out_valid; pd = out_data; pdst = out_dest; prdy = out_ready;
            nvec++;
            if ((D0_rd && D1_rd) || (D0_rd && prd0) || (D1_rd && prd1)) begin
                nerr++;
                $display("FAIL %s rd_pulse: got rd0=%b rd1=%b prev=%b%b want single one-cycle strobe",
                         name, D0_rd, D1_rd, prd0, prd1);
            end
            prd0 = D0_rd; prd1 = D1_rd;
            tick();
            if (pv && !prdy) begin
                nvec++;
                if (out_valid !== 1'b1 || out_data !== pd || out_dest !== pdst) begin
                    nerr++;
                    $display("FAIL %s hold_stable: got v=%b d=%h dst=%b want v=1 d=%h dst=%b",
                             name, out_valid, out_data, out_dest, pd, pdst);
                end
            end
            if (x_fire) begin
                e = expq.pop_front();
                nvec++;
                if ({x_dest, x_data} !== e || cyc - last_fire < 4) begin
                    nerr++;
                    $display("FAIL %s word: got dst=%b d=%h gap=%0d want dst=%b d=%h gap>=4",
                             name, x_dest, x_data, cyc - last_fire, e[BW], e[BW-1:0]);
                end
                last_fire = cyc;
                model_xfer(e);
            end
        end
        nvec++;
        if (expq.size() != 0) begin
            nerr++;
            $display("FAIL %s timeout: got %0d words left want 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic read_cnt(input int idx, input string name);
        logic [CNT_W-1:0] want;
        logic [CNT_W-1:0] held;
        want = CNT_W'(m_cnt[idx]);
        cnt_req = 1'b1;
        cnt_idx = idx[0];
        tick();
        nvec++;
        if (cnt_valid !== 1'b1 || cnt_value !== want) begin
            nerr++;
            $display("FAIL %s cnt%0d: got v=%b val=%0d want v=1 val=%0d",
                     name, idx, cnt_valid, cnt_value, want);
        end
        held = cnt_value;
        cnt_req = 1'b0;
        tick();
        nvec++;
        if (cnt_valid !== 1'b0 || cnt_value !== held) begin
            nerr++;
            $display("FAIL %s cnt%0d_drop: got v=%b val=%0d want v=0 val=%0d",
                     name, idx, cnt_valid, cnt_value, held);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
        m_last = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic test_reset();
        nvec++;
        if (D0_rd !== 1'b0 || D1_rd !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
            out_dest !== 1'b0 || cnt_valid !== 1'b0 || cnt_value !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got rd=%b%b v=%b d=%h dst=%b cv=%b cval=%0d want all 0",
                     D0_rd, D1_rd, out_valid, out_data, out_dest, cnt_valid, cnt_value);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++;
            if (idle_out !== 1'b1 || D0_rd !== 1'b0 || D1_rd !== 1'b0 || out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL reset_idle: got idle=%b rd=%b%b v=%b want idle=1 rd=00 v=0",
                         idle_out, D0_rd, D1_rd, out_valid);
            end
        end
        read_cnt(0, "reset");
        read_cnt(1, "reset");
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        m0.push_back(6'h05);
        build_model("single");
        tick();
        nvec++;
        if (D0_rd !== 1'b1 || D1_rd !== 1'b0) begin
            nerr++;
            $display("FAIL single_rd: got rd=%b%b want 10", D0_rd, D1_rd);
        end
        tick();
        nvec++;
        if (D0_rd !== 1'b0 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL single_rd_drop: got rd0=%b v=%b want 0 0", D0_rd, out_valid);
        end
        tick();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 6'h05 || out_dest !== 1'b0) begin
            nerr++;
            $display("FAIL single_out: got v=%b d=%h dst=%b want v=1 d=05 dst=0",
                     out_valid, out_data, out_dest);
        end
        run_drain("single", 100, 10);
        read_cnt(0, "single");
    endtask

    task automatic test_round_robin();
        do_reset();
        out_ready = 1'b1;
        m0.push_back(6'h01); m0.push_back(6'h02);
        m1.push_back(6'h21); m1.push_back(6'h22);
        build_model("rr");
        run_drain("rr", 100, 40);
        read_cnt(0, "rr");
        read_cnt(1, "rr");
    endtask

    task automatic test_backpressure();
        logic [BW:0] e;
        logic [BW-1:0] d;
        logic dst;
        int n;
        out_ready = 1'b0;
        m0.push_back(6'h0A); m0.push_back(6'h0B); m1.push_back(6'h1C);
        build_model("bp");
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin tick(); n++; end
        nvec++;
        if (out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL bp_wait: got v=%b want 1 within 10 cycles", out_valid);
        end
        d = out_data; dst = out_dest;
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++;
            if (out_valid !== 1'b1 || out_data !== d || out_dest !== dst || D0_rd || D1_rd) begin
                nerr++;
                $display("FAIL bp_hold: got v=%b d=%h dst=%b rd=%b%b want v=1 d=%h dst=%b rd=00",
                         out_valid, out_data, out_dest, D0_rd, D1_rd, d, dst);
            end
        end
        out_ready = 1'b1;
        tick();
        e = expq.pop_front();
        nvec++;
        if (x_fire !== 1'b1 || {x_dest, x_data} !== e || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL bp_release: got fire=%b dst=%b d=%h v=%b want fire=1 dst=%b d=%h v=0",
                     x_fire, x_dest, x_data, out_valid, e[BW], e[BW-1:0]);
        end
        model_xfer(e);
        run_drain("bp_rest", 100, 40);
    endtask

    task automatic test_random();
        int n0, n1;
        for (int it = 0; it < 12; it++) begin
            n0 = $urandom_range(5);
            n1 = $urandom_range(5);
            for (int k = 0; k < n0; k++) m0.push_back(BW'($urandom));
            for (int k = 0; k < n1; k++) m1.push_back(BW'($urandom));
            build_model("rand");
            run_drain("rand", $urandom_range(100, 30), 200);
        end
        read_cnt(0, "rand");
        read_cnt(1, "rand");
    endtask

    task automatic test_saturate_init();
        logic [BW:0] e;
        int n;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) m1.push_back(BW'(k));
        build_model("sat");
        run_drain("sat", 100, 400);
        read_cnt(1, "sat");
        out_ready = 1'b0;
        m1.push_back(6'h3F);
        build_model("init");
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin tick(); n++; end
        init = 1'b1;
        out_ready = 1'b1;
        tick();
        init = 1'b0;
        e = expq.pop_front();
        nvec++;
        if (x_fire !== 1'b1 || {x_dest, x_data} !== e) begin
            nerr++;
            $display("FAIL init_xfer: got fire=%b dst=%b d=%h want fire=1 dst=%b d=%h",
                     x_fire, x_dest, x_data, e[BW], e[BW-1:0]);
        end
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        read_cnt(1, "init");
        read_cnt(0, "init");
    endtask

    task automatic test_reset_capt();
        out_ready = 1'b1;
        q0.push_back(6'h2A);
        D0_empty = 1'b0;
        tick();
        tick();
        #2;
        reset_L = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || D0_rd !== 1'b0 || D1_rd !== 1'b0) begin
            nerr++;
            $display("FAIL rst_capt: got v=%b rd=%b%b want v=0 rd=00", out_valid, D0_rd, D1_rd);
        end
        tick();
        tick();
        reset_L = 1'b1;
        m_last = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        nvec++;
        if (out_valid !== 1'b0 || idle_out !== 1'b1) begin
            nerr++;
            $display("FAIL rst_capt_after: got v=%b idle=%b want v=0 idle=1", out_valid, idle_out);
        end
        read_cnt(0, "rst_capt");
        read_cnt(1, "rst_capt");
        m0.push_back(6'h11);
        m1.push_back(6'h31);
        build_model("rst_capt_next");
        run_drain("rst_capt_next", 100, 40);
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_random();
        test_saturate_init();
        test_reset_capt();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
